imm_ext_pipe: RTL
=================

Name: imm_ext_pipe

Overview:
Registered, handshaked immediate-extension stage for the miniLA pipelined core. It sits between decode and execute. It accepts {inst, ext_op, tag}, produces the XLEN-bit extended immediate one cycle later, and buffers up to DEPTH results so execute stalls never drop an immediate. It generalises the single-cycle 12/16/28-bit sign-extend and 12-bit zero-extend logic to eight LoongArch immediate formats, parametrised width and depth, and a flush input.

Parameters:
XLEN, 32, result width (32 or 64); sign/zero extension fills to XLEN.
DEPTH, 2, output buffer entries (>=1); 2 gives full throughput under backpressure.
TAG_W, 8, width of opaque tag passed alongside each immediate.

Ports:
cpu_clk  in  1  clock, all state on rising edge
cpu_rst  in  1  synchronous active-high reset
flush  in  1  synchronous discard of all buffered entries
in_valid  in  1  upstream has a request
in_ready  out  1  stage can accept this cycle
in_inst  in  32  raw instruction word
in_ext_op  in  3  format select (package encodings)
in_tag  in  TAG_W  passthrough tag
out_valid  out  1  head entry valid
out_ready  in  1  downstream consumes head
out_imm  out  XLEN  extended immediate of head entry
out_tag  out  TAG_W  tag of head entry

Behaviour:
- Clocking: one clock; reset is synchronous and active-high on cpu_rst, sampled on cpu_clk rising edge.
- ext_op encodings, where S = sign-extend to XLEN and Z = zero-extend:
  - 0 NONE = 0.
  - 1 SI12 = S(inst[21:10]).
  - 2 UI12 = Z(inst[21:10]).
  - 3 SI14S2 = S({inst[23:10],2'b0}).
  - 4 SI16S2 = S({inst[25:10],2'b0}).
  - 5 SI20S12 = S({inst[24:5],12'b0}).
  - 6 OFFS26S2 = S({inst[9:0],inst[25:10],2'b0}).
  - 7 UI5 = Z(inst[14:10]).
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- in_ready = (count != DEPTH) && !cpu_rst. It is combinational from state only, never from in_valid.
- Latency: a request pushed in cycle N appears on out_* in cycle N+1 if the buffer was empty. Otherwise it appears in FIFO order.
- out_valid = (count != 0). While out_valid && !out_ready, out_imm and out_tag hold stable.
- Simultaneous push and pop: count unchanged; head advances and the new entry is appended.
  - At count == DEPTH no push occurs because in_ready = 0.
- Pop from count == 1 with push in the same cycle: out_valid stays 1 and the new entry is presented next cycle.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH+1) bits.
- flush: count <= 0 and pointers <= 0 next cycle. Flush has priority over push and pop in the same cycle; a concurrent push is dropped.
- cpu_rst: count, pointers <= 0; out_valid = 0; out_imm = 0; out_tag = 0; in_ready = 0 during reset, 1 the cycle after.
  - Reset mid-stream discards all entries.
- When out_valid = 0, out_imm and out_tag are driven 0, not stale data.

Optional Feature:
Macro IMM_EXT_PCREL_EN.
- Defined:
  - Adds ports in_pc (XLEN, in) and out_target (XLEN, out).
  - Each entry also stores in_pc + extended immediate, computed at push and wrapping modulo 2^XLEN.
  - out_target follows the same valid/hold/reset-to-0 rules as out_imm. Used for branch/pcaddu12i targets.
- Undefined: neither port exists and no adder is built. Behaviour is otherwise identical.

Decomposition:
- Shared package imm_ext_pkg holds:
  - localparam encodings IMM_OP_NONE..IMM_OP_UI5 (3 bits);
  - IMM_OP_W = 3;
  - typedef imm_op_t.
- One sub-module: imm_ext_comb, a purely combinational (inst, op) -> XLEN-bit immediate decoder.
  - imm_ext_pipe instantiates it at the push side, plus the buffer/handshake logic.

Test Plan:
- Reset, then in_inst=0x02BFFC00: op=SI12 -> out_imm=0xFFFFFFFF one cycle later; op=UI12 -> 0x00000FFF; op=UI5 -> 0x0000001F.
- in_inst=0x15000000, op=SI20S12 -> 0x80000000; in_inst=0x50000200, op=OFFS26S2 -> 0xF8000000; XLEN=64 -> 0xFFFFFFFFF8000000.
- Hold out_ready=0 and push 3 requests with tags 1, 2, 3 -> in_ready drops after 2 accepts and out_imm/out_tag hold tag 1. Release out_ready -> tags emerge 1, 2, 3 with no loss.
- Continuous in_valid=1, out_ready=1 for 16 cycles -> one result per cycle, in_ready never drops, order preserved.
- With 2 entries buffered, assert flush together with in_valid=1 -> next cycle out_valid=0, count=0, and the flushed push never appears.
- IMM_EXT_PCREL_EN: in_pc=0x1C000010, in_inst=0x50000200, op=OFFS26S2 -> out_target=0x14000010. Assert cpu_rst mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension stage: format-select
// encodings and small sizing helpers used by imm_ext_pipe and imm_ext_comb.
// Optional feature macro used by imm_ext_pipe: IMM_EXT_PCREL_EN.
package imm_ext_pkg;

  localparam int IMM_OP_W = 3;

  typedef logic [IMM_OP_W-1:0] imm_op_t;

  // Immediate format encodings carried on in_ext_op.
  localparam imm_op_t IMM_OP_NONE     = 3'd0;
  localparam imm_op_t IMM_OP_SI12     = 3'd1;
  localparam imm_op_t IMM_OP_UI12     = 3'd2;
  localparam imm_op_t IMM_OP_SI14S2   = 3'd3;
  localparam imm_op_t IMM_OP_SI16S2   = 3'd4;
  localparam imm_op_t IMM_OP_SI20S12  = 3'd5;
  localparam imm_op_t IMM_OP_OFFS26S2 = 3'd6;
  localparam imm_op_t IMM_OP_UI5      = 3'd7;

  // Pointer width for a buffer of 'depth' entries; a single-entry buffer
  // still gets a 1-bit pointer so the declarations stay legal.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imm_ext_comb.sv
// Purely combinational immediate decoder: selects one of eight LoongArch
// immediate fields from the instruction word and sign/zero-extends it to
// XLEN bits. NONE (and any unused code) yields zero.
module imm_ext_comb
  import imm_ext_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  imm_op_t         op,
  output logic [XLEN-1:0] imm
);

  // Raw fields, already shifted into their final bit positions. The signed
  // ones rely on the size cast below to sign-extend to XLEN.
  logic signed [11:0] si12;
  logic        [11:0] ui12;
  logic signed [15:0] si14s2;
  logic signed [17:0] si16s2;
  logic signed [31:0] si20s12;
  logic signed [27:0] offs26s2;
  logic        [4:0]  ui5;

  assign si12     = inst[21:10];
  assign ui12     = inst[21:10];
  assign si14s2   = {inst[23:10], 2'b00};
  assign si16s2   = {inst[25:10], 2'b00};
  assign si20s12  = {inst[24:5], 12'b0};
  assign offs26s2 = {inst[9:0], inst[25:10], 2'b00};
  assign ui5      = inst[14:10];

  // The opcode bits never contribute to an immediate.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^inst[31:26];

  // Format select with extension to XLEN.
  always_comb begin
    imm = '0;
    unique case (op)
      IMM_OP_SI12:     imm = XLEN'(si12);
      IMM_OP_UI12:     imm = XLEN'(ui12);
      IMM_OP_SI14S2:   imm = XLEN'(si14s2);
      IMM_OP_SI16S2:   imm = XLEN'(si16s2);
      IMM_OP_SI20S12:  imm = XLEN'(si20s12);
      IMM_OP_OFFS26S2: imm = XLEN'(offs26s2);
      IMM_OP_UI5:      imm = XLEN'(ui5);
      default:         imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered, handshaked immediate-extension stage between decode and
// execute. Requests are decoded at the push side and stored in a DEPTH-entry
// FIFO, so a result pushed into an empty buffer is visible the next cycle and
// execute stalls never lose an entry. flush and cpu_rst empty the buffer.
// Optional feature: define IMM_EXT_PCREL_EN to add in_pc/out_target, where
// each entry also carries in_pc + immediate (modulo 2^XLEN).
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 8
) (
  input  logic                cpu_clk,
  input  logic                cpu_rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [IMM_OP_W-1:0] in_ext_op,
  input  logic [TAG_W-1:0]    in_tag,
`ifdef IMM_EXT_PCREL_EN
  input  logic [XLEN-1:0]     in_pc,
  output logic [XLEN-1:0]     out_target,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_imm,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = ptr_width(DEPTH);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  // Occupancy and ring pointers.
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  // Entry storage; contents are only meaningful below count_q, so no reset.
  logic [XLEN-1:0]  imm_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic             push;
  logic             pop;
  logic             wr_en;
  logic [XLEN-1:0]  push_imm;

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : (p + PTR_ONE);
  endfunction

  // Decode the immediate for the incoming request.
  imm_ext_comb #(
    .XLEN (XLEN)
  ) u_dec (
    .inst (in_inst),
    .op   (imm_op_t'(in_ext_op)),
    .imm  (push_imm)
  );

  // Ready depends on state only, never on in_valid.
  assign in_ready  = (count_q != DEPTH_C) && !cpu_rst;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // A push coinciding with flush is dropped.
  assign wr_en     = push && !flush;

  // Next-state for occupancy and pointers; flush overrides push and pop.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Write the decoded immediate and tag into the tail slot.
  always_ff @(posedge cpu_clk) begin
    if (wr_en) begin
      imm_mem[wr_ptr_q] <= push_imm;
      tag_mem[wr_ptr_q] <= in_tag;
    end
  end

  // Present the head entry; outputs read zero whenever the buffer is empty.
  always_comb begin
    out_imm = '0;
    out_tag = '0;
    if (out_valid) begin
      out_imm = imm_mem[rd_ptr_q];
      out_tag = tag_mem[rd_ptr_q];
    end
  end

`ifdef IMM_EXT_PCREL_EN
  logic [XLEN-1:0] tgt_mem [DEPTH];
  logic [XLEN-1:0] push_tgt;

  // PC-relative target computed once at push, wrapping modulo 2^XLEN.
  assign push_tgt = in_pc + push_imm;

  // Store the target alongside its immediate.
  always_ff @(posedge cpu_clk) begin
    if (wr_en) begin
      tgt_mem[wr_ptr_q] <= push_tgt;
    end
  end

  // Head target, zero when no entry is valid.
  always_comb begin
    out_target = '0;
    if (out_valid) begin
      out_target = tgt_mem[rd_ptr_q];
    end
  end
`endif

endmodule
